// File: rtl/zero_detector_pkg.sv
// Shared constants and helpers for the zero detector.
// Optional leading-zero count: define ZERO_DETECTOR_LZC_EN.
package zero_detector_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int RUN_W_DEF = 8;

  typedef logic [RUN_W_DEF-1:0] run_cnt_t;

  // Wide enough to hold a count of WIDTH (the all-zero operand).
  function automatic int lzc_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/zd_or_tree.sv
// Recursive balanced OR reduction; with ZERO_DETECTOR_LZC_EN it also
// produces the leading-zero count of the operand. Purely combinational.
module zd_or_tree
  import zero_detector_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]          a,
  output logic                  any
`ifdef ZERO_DETECTOR_LZC_EN
  ,
  output logic [lzc_w(W)-1:0]   lzc
`endif
);

  generate
    if (W == 1) begin : g_leaf
      assign any = a[0];
`ifdef ZERO_DETECTOR_LZC_EN
      assign lzc = ~a[0];
`endif
    end else begin : g_node
      localparam int LO_W = W / 2;
      localparam int HI_W = W - LO_W;

      logic any_hi, any_lo;
`ifdef ZERO_DETECTOR_LZC_EN
      localparam int LW = lzc_w(W);
      logic [lzc_w(HI_W)-1:0] lzc_hi;
      logic [lzc_w(LO_W)-1:0] lzc_lo;
`endif

      zd_or_tree #(.W(HI_W)) u_hi (
        .a   (a[W-1:LO_W]),
        .any (any_hi)
`ifdef ZERO_DETECTOR_LZC_EN
        ,
        .lzc (lzc_hi)
`endif
      );

      zd_or_tree #(.W(LO_W)) u_lo (
        .a   (a[LO_W-1:0]),
        .any (any_lo)
`ifdef ZERO_DETECTOR_LZC_EN
        ,
        .lzc (lzc_lo)
`endif
      );

      assign any = any_hi | any_lo;
`ifdef ZERO_DETECTOR_LZC_EN
      // An all-zero upper half contributes its full width, then the lower half counts on.
      assign lzc = any_hi ? LW'(lzc_hi) : LW'(HI_W) + LW'(lzc_lo);
`endif
    end
  endgenerate

endmodule

// File: rtl/zero_detector.sv
// Registered zero flag with saturating zero-run counter.
// Optional registered leading-zero count: define ZERO_DETECTOR_LZC_EN.
module zero_detector
  import zero_detector_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RUN_W = RUN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         a,
  input  logic                     a_valid,
  output logic                     y,
  output logic                     y_valid,
  output logic [RUN_W-1:0]         zero_run
`ifdef ZERO_DETECTOR_LZC_EN
  ,
  output logic [lzc_w(WIDTH)-1:0]  lzc
`endif
);

  logic any;
  logic z;
`ifdef ZERO_DETECTOR_LZC_EN
  logic [lzc_w(WIDTH)-1:0] lzc_c;
`endif

  zd_or_tree #(.W(WIDTH)) u_tree (
    .a   (a),
    .any (any)
`ifdef ZERO_DETECTOR_LZC_EN
    ,
    .lzc (lzc_c)
`endif
  );

  assign z = ~any;

  // Idle cycles leave y/zero_run untouched, so a gap never breaks a run.
  always_ff @(posedge clk) begin
    if (rst) begin
      y        <= 1'b0;
      y_valid  <= 1'b0;
      zero_run <= '0;
`ifdef ZERO_DETECTOR_LZC_EN
      lzc      <= '0;
`endif
    end else begin
      y_valid <= a_valid;
      if (a_valid) begin
        y <= z;
`ifdef ZERO_DETECTOR_LZC_EN
        lzc <= lzc_c;
`endif
        if (!z)
          zero_run <= '0;
        else if (zero_run != '1)
          zero_run <= zero_run + RUN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_zero_detector.sv
// Self-checking bench for zero_detector: directed scenarios plus random traffic
// against a behavioural model; a second instance uses RUN_W=2 for saturation.
module tb_zero_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic       a_valid;

  logic       y, y_valid, y2, y_valid2;
  logic [7:0] zero_run;
  logic [1:0] zero_run2;
`ifdef ZERO_DETECTOR_LZC_EN
  logic [3:0] lzc, lzc2;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic exp_y, exp_yv;
  int   exp_run, exp_run2, exp_lzc;

  always #5 clk = ~clk;

  zero_detector #(.WIDTH(8), .RUN_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid),
    .y(y), .y_valid(y_valid), .zero_run(zero_run)
`ifdef ZERO_DETECTOR_LZC_EN
    , .lzc(lzc)
`endif
  );

  zero_detector #(.WIDTH(8), .RUN_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid),
    .y(y2), .y_valid(y_valid2), .zero_run(zero_run2)
`ifdef ZERO_DETECTOR_LZC_EN
    , .lzc(lzc2)
`endif
  );

  function automatic int ref_lzc(input logic [7:0] d);
    int n = 0;
    for (int i = 7; i >= 0; i--) begin
      if (d[i]) return n;
      n++;
    end
    return n;
  endfunction

  // Drive one cycle of stimulus, then advance the model to what the outputs should show.
  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    rst = r; a_valid = v; a = d;
    @(posedge clk); #1;
    if (r) begin
      exp_y = 0; exp_yv = 0; exp_run = 0; exp_run2 = 0; exp_lzc = 0;
    end else if (v) begin
      exp_y    = (d == 8'd0);
      exp_yv   = 1;
      exp_run  = (d == 8'd0) ? ((exp_run  < 255) ? exp_run  + 1 : 255) : 0;
      exp_run2 = (d == 8'd0) ? ((exp_run2 < 3)   ? exp_run2 + 1 : 3)   : 0;
      exp_lzc  = ref_lzc(d);
    end else begin
      exp_yv = 0;
    end
  endtask

  task automatic test_reset;
    drive(1, 1, 8'h00);
    drive(1, 0, 8'h5A);
    n_vec++; if (y !== 1'b0) begin n_bad++; $display("FAIL reset.y got %0b want 0", y); end
    n_vec++; if (y_valid !== 1'b0) begin n_bad++; $display("FAIL reset.y_valid got %0b want 0", y_valid); end
    n_vec++; if (zero_run !== 8'd0) begin n_bad++; $display("FAIL reset.zero_run got %0d want 0", zero_run); end
    n_vec++; if (zero_run2 !== 2'd0) begin n_bad++; $display("FAIL reset.zero_run2 got %0d want 0", zero_run2); end
`ifdef ZERO_DETECTOR_LZC_EN
    n_vec++; if (lzc !== 4'd0) begin n_bad++; $display("FAIL reset.lzc got %0d want 0", lzc); end
`endif
    drive(0, 1, 8'h00);
    n_vec++; if (y !== 1'b1) begin n_bad++; $display("FAIL first.y got %0b want 1", y); end
    n_vec++; if (y_valid !== 1'b1) begin n_bad++; $display("FAIL first.y_valid got %0b want 1", y_valid); end
    n_vec++; if (zero_run !== 8'd1) begin n_bad++; $display("FAIL first.zero_run got %0d want 1", zero_run); end
  endtask

  task automatic test_clear;
    int steps [4] = '{1, 2, 3, 0};
    logic [7:0] seq [4] = '{8'h00, 8'h00, 8'h00, 8'h33};
    drive(1, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, seq[i]);
      n_vec++; if (zero_run !== 8'(steps[i])) begin n_bad++; $display("FAIL clear.zero_run[%0d] got %0d want %0d", i, zero_run, steps[i]); end
      n_vec++; if (y !== exp_y) begin n_bad++; $display("FAIL clear.y[%0d] got %0b want %0b", i, y, exp_y); end
      n_vec++; if (y_valid !== 1'b1) begin n_bad++; $display("FAIL clear.y_valid[%0d] got %0b want 1", i, y_valid); end
    end
`ifdef ZERO_DETECTOR_LZC_EN
    n_vec++; if (lzc !== 4'd2) begin n_bad++; $display("FAIL clear.lzc got %0d want 2", lzc); end
`endif
  endtask

  task automatic test_gap;
    logic       vs [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] ds [5] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
    drive(1, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      drive(0, vs[i], ds[i]);
      n_vec++; if (y_valid !== vs[i]) begin n_bad++; $display("FAIL gap.y_valid[%0d] got %0b want %0b", i, y_valid, vs[i]); end
      n_vec++; if (y !== 1'b1) begin n_bad++; $display("FAIL gap.y[%0d] got %0b want 1", i, y); end
      n_vec++; if (zero_run !== 8'(exp_run)) begin n_bad++; $display("FAIL gap.zero_run[%0d] got %0d want %0d", i, zero_run, exp_run); end
    end
    n_vec++; if (zero_run !== 8'd3) begin n_bad++; $display("FAIL gap.final_run got %0d want 3", zero_run); end
  endtask

  task automatic test_boundary;
    logic [7:0] ds [6] = '{8'h01, 8'h80, 8'h00, 8'hFF, 8'h10, 8'h00};
    logic       ys [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int         ls [6] = '{7, 0, 8, 0, 3, 8};
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, ds[i]);
      n_vec++; if (y !== ys[i]) begin n_bad++; $display("FAIL bound.y[%02h] got %0b want %0b", ds[i], y, ys[i]); end
      n_vec++; if (y2 !== ys[i]) begin n_bad++; $display("FAIL bound.y2[%02h] got %0b want %0b", ds[i], y2, ys[i]); end
`ifdef ZERO_DETECTOR_LZC_EN
      n_vec++; if (lzc !== 4'(ls[i])) begin n_bad++; $display("FAIL bound.lzc[%02h] got %0d want %0d", ds[i], lzc, ls[i]); end
`else
      if (ls[i] < 0) $display("bad table");
`endif
    end
  endtask

  task automatic test_saturation;
    int sat [5] = '{1, 2, 3, 3, 3};
    drive(1, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'h00);
      n_vec++; if (zero_run2 !== 2'(sat[i])) begin n_bad++; $display("FAIL sat2.zero_run[%0d] got %0d want %0d", i, zero_run2, sat[i]); end
    end
    for (int i = 0; i < 255; i++) drive(0, 1, 8'h00);
    n_vec++; if (zero_run !== 8'd255) begin n_bad++; $display("FAIL sat8.zero_run got %0d want 255", zero_run); end
    drive(0, 1, 8'h00);
    n_vec++; if (zero_run !== 8'd255) begin n_bad++; $display("FAIL sat8.hold got %0d want 255", zero_run); end
    drive(0, 1, 8'h40);
    n_vec++; if (zero_run !== 8'd0) begin n_bad++; $display("FAIL sat8.clear got %0d want 0", zero_run); end
    n_vec++; if (zero_run2 !== 2'd0) begin n_bad++; $display("FAIL sat2.clear got %0d want 0", zero_run2); end
  endtask

  task automatic test_reset_mid_run;
    drive(1, 0, 8'h00);
    drive(0, 1, 8'h00);
    drive(0, 1, 8'h00);
    n_vec++; if (zero_run !== 8'd2) begin n_bad++; $display("FAIL midrst.pre got %0d want 2", zero_run); end
    drive(1, 1, 8'h00);
    n_vec++; if (y !== 1'b0) begin n_bad++; $display("FAIL midrst.y got %0b want 0", y); end
    n_vec++; if (y_valid !== 1'b0) begin n_bad++; $display("FAIL midrst.y_valid got %0b want 0", y_valid); end
    n_vec++; if (zero_run !== 8'd0) begin n_bad++; $display("FAIL midrst.zero_run got %0d want 0", zero_run); end
  endtask

  task automatic test_random;
    logic       r, v;
    logic [7:0] d;
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0, 1:    d = 8'h00;
        2:       d = 8'h01 << $urandom_range(0, 7);
        default: d = 8'($urandom);
      endcase
      drive(r, v, d);
      n_vec++; if (y !== exp_y) begin n_bad++; $display("FAIL rand.y[%0d] got %0b want %0b", i, y, exp_y); end
      n_vec++; if (y_valid !== exp_yv) begin n_bad++; $display("FAIL rand.y_valid[%0d] got %0b want %0b", i, y_valid, exp_yv); end
      n_vec++; if (zero_run !== 8'(exp_run)) begin n_bad++; $display("FAIL rand.zero_run[%0d] got %0d want %0d", i, zero_run, exp_run); end
      n_vec++; if (zero_run2 !== 2'(exp_run2)) begin n_bad++; $display("FAIL rand.zero_run2[%0d] got %0d want %0d", i, zero_run2, exp_run2); end
      n_vec++; if (y_valid2 !== exp_yv) begin n_bad++; $display("FAIL rand.y_valid2[%0d] got %0b want %0b", i, y_valid2, exp_yv); end
`ifdef ZERO_DETECTOR_LZC_EN
      n_vec++; if (lzc !== 4'(exp_lzc)) begin n_bad++; $display("FAIL rand.lzc[%0d] got %0d want %0d", i, lzc, exp_lzc); end
      n_vec++; if (lzc2 !== 4'(exp_lzc)) begin n_bad++; $display("FAIL rand.lzc2[%0d] got %0d want %0d", i, lzc2, exp_lzc); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; a = 8'h00;
    exp_y = 0; exp_yv = 0; exp_run = 0; exp_run2 = 0; exp_lzc = 0;
    test_reset;
    test_clear;
    test_gap;
    test_boundary;
    test_saturation;
    test_reset_mid_run;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/zero_detector.md
# zero_detector

Registered 8-bit (parameterisable) zero detector for the datapath status logic. Samples an operand word each cycle and flags, one clock later, whether every bit was zero. It also keeps a saturating count of consecutive zero-valued samples, which feeds the processor's condition/status path. An optional leading-zero count is compiled in for normalisation logic.

## Interface
Parameters:
- WIDTH, 8: operand width in bits; minimum 2.
- RUN_W, 8: width of the zero-run counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand to test.
- a_valid  in  1  a is sampled only when high.
- y  out  1  registered zero flag: 1 when the last sampled a was all zeros.
- y_valid  out  1  high for exactly one cycle per sampled operand.
- zero_run  out  RUN_W  count of consecutive sampled zero operands, saturating.
- lzc  out  $clog2(WIDTH)+1  leading-zero count of the last sampled a. Present only with ZERO_DETECTOR_LZC_EN.

## Operation
- Combinational detect: z = ~|a, built as a balanced 2-input OR reduction tree, then inverted.
- On a clock edge with rst=0 and a_valid=1: y <= z; y_valid <= 1.
  - If z=1, zero_run <= zero_run+1, saturating at 2^RUN_W-1.
  - If z=0, zero_run <= 0.
- On a clock edge with rst=0 and a_valid=0: y and zero_run hold; y_valid <= 0.
- An a_valid=0 cycle does not break a zero run. Only a sampled non-zero operand clears zero_run.
- X on a while a_valid=0 must not propagate into state.
- The block has no handshake back-pressure; every valid sample is accepted.

## Timing
- Reset values: y=0, y_valid=0, zero_run=0, lzc=0.
- Latency: 1 clock from the a_valid sample edge to y, y_valid and zero_run.
- Throughput: one operand per clock.
- Reset asserted in the same cycle as a_valid: reset wins and the sample is discarded.
- Saturation: at zero_run=2^RUN_W-1, a further zero sample holds the value (no wrap). A non-zero sample still clears it to 0.
- a=all-ones and a=single LSB set both give y=0.

## Configuration
- ZERO_DETECTOR_LZC_EN defined:
  - lzc is added as a port and registered on the same edge and with the same enable as y.
  - lzc is the number of zero bits from the MSB down to the first 1.
  - lzc=WIDTH when a=0. Example: a=8'h33 gives lzc=2.
- Not defined: the lzc port and its logic are absent. All other behaviour is identical.

## Structure
- A shared package zero_detector_pkg holds:
  - the default WIDTH and RUN_W constants;
  - a function computing the lzc width, $clog2(WIDTH)+1;
  - a typedef for the run-counter type.
- One sub-module, zd_or_tree:
  - parameterised recursive OR reduction;
  - also returns the leading-zero count when ZERO_DETECTOR_LZC_EN is defined;
  - purely combinational.
- The top level holds only the registers, the run counter and the enable/reset logic.

## Test plan
- Reset, then one sample: hold rst=1 for 2 cycles, release. Drive a=8'h00, a_valid=1 for one cycle -> next edge y=1, y_valid=1, zero_run=1.
- Non-zero clears the run: a=8'h00 for 3 valid cycles, then a=8'h33 -> zero_run steps 1,2,3 with y=1, then y=0 and zero_run=0. With LZC enabled, lzc=2.
- Idle gap: zero, zero, a_valid=0 for 2 cycles (a=8'hFF), zero -> y_valid low during the gap, y holds 1, zero_run ends at 3.
- Boundary values: a=8'h01 and a=8'h80 -> y=0. With LZC enabled, lzc=7 and lzc=0 respectively. a=8'h00 -> lzc=8.
- Saturation with RUN_W=2: 5 consecutive zero samples -> zero_run=1,2,3,3,3.
- Reset mid-run: zero_run=2, then assert rst together with a_valid=1, a=0 -> next edge y=0, y_valid=0, zero_run=0.
